uart_rx_cfg: RTL and testbench
==============================

Name: uart_rx_cfg

Overview:
Runtime-configurable UART receiver supporting 5-9 data bits, none/even/odd parity, 1 or 2 stop bits and a programmable baud divisor. Each bit is sampled as a 3-sample majority vote at mid-bit. Received frames are buffered in an internal FIFO with a ready/valid output, and the block adds break detection and sticky overrun reporting. It sits between the board RX pin and host-side consumers such as a debug/loader bridge.

Parameters:
max_data_bits_p, 9, width of rx_o; runtime data bits must not exceed it.
clk_div_width_p, 16, width of the baud divisor input.
fifo_els_p, 4, receive FIFO depth in entries; must be at least 2.

Ports:
clk_i  input  1  clock
reset_i  input  1  synchronous, active-high reset
rx_i  input  1  asynchronous serial line; idles high
cfg_clk_per_bit_i  input  clk_div_width_p  clocks per bit; legal range is 4 or more
cfg_data_bits_i  input  4  data bits per frame, 5..9
cfg_parity_en_i  input  1  1 = parity bit present
cfg_parity_odd_i  input  1  1 = odd parity, 0 = even
cfg_two_stop_i  input  1  1 = two stop bits
rx_v_o  output  1  FIFO head valid
rx_o  output  max_data_bits_p  head data, LSB = first bit received, unused upper bits 0
rx_parity_error_o  output  1  head entry's parity error flag
rx_frame_error_o  output  1  head entry's framing error flag
rx_ready_and_i  input  1  consumer accepts head when high together with rx_v_o
rx_break_o  output  1  one-cycle pulse when a break is detected
overrun_o  output  1  sticky: a frame was dropped because the FIFO was full
overrun_clr_i  input  1  clears overrun_o
busy_o  output  1  FSM not in IDLE

Behaviour:
- rx_i passes through a 2-flop synchronizer. Both flops reset to 1, so reset never produces a false start.
- Config is captured into registers when a start edge is detected. Config changes mid-frame have no effect until the next frame.
- Define mid = cfg_clk_per_bit >> 1. A bit value is the majority of synced samples at bit-relative counts mid-1, mid and mid+1.
- The bit counter runs 0..cfg_clk_per_bit-1, then wraps and advances to the next bit.
- States:
  - IDLE: a synced 1→0 edge moves to START and zeros the counter.
  - START: majority 1 at the vote point returns to IDLE (glitch reject, no output). Majority 0 moves on at the end of the bit period.
  - DATA: collects cfg_data_bits bits LSB-first, then moves to PARITY if enabled, else STOP.
  - PARITY: captures parity bit p. Parity error = (^data) ^ p ^ cfg_parity_odd.
  - STOP: samples 1 or 2 stop bits. A framing error is any stop sample of 0.
  - WAIT_HIGH: stays until synced line = 1, then goes to IDLE.
- Completion: the entry {data, parity_err, frame_err} is pushed on the vote cycle of the last stop bit. The FSM then goes to IDLE if that stop bit sampled 1, else WAIT_HIGH.
- Break: data all 0, parity bit 0 (if enabled), and the first stop bit 0.
  - Pulse rx_break_o for 1 cycle; no FIFO push.
  - Skip any second stop bit and go to WAIT_HIGH.
- FIFO handshake:
  - Pop when rx_v_o & rx_ready_and_i.
  - rx_v_o rises the cycle after a push into an empty FIFO; there is no fall-through.
  - Outputs hold stable while rx_v_o=1 and not popped.
- Full FIFO:
  - A push with no pop in the same cycle drops the frame and sets overrun_o.
  - A push and a pop in the same cycle when full both succeed, with no overrun.
  - overrun_clr_i clears overrun_o; if clear and a new overrun occur in the same cycle, the set wins.
- Reset values: rx_v_o=0, rx_o=0, both error outputs 0, rx_break_o=0, overrun_o=0, busy_o=0, FIFO empty, state IDLE.
- Reset asserted mid-frame discards the partial frame and all FIFO contents.
- Pointers wrap modulo fifo_els_p. A separate count or extra pointer bit distinguishes full from empty.

Test Plan:
- Divisor 16, 8N1, send 0xA5 with ready held 1 → one rx_v_o pulse, rx_o=0x0A5, no errors, rx_v_o rises 1 cycle after the mid-vote of the stop bit.
- Divisor 16, 7 bits, even parity, 2 stop bits; send 0x35 with parity bit 1 (wrong) → rx_o=0x035, rx_parity_error_o=1; the same frame with parity bit 0 → no error.
- Divisor 8, 9 bits, odd parity; send 0x1FF with parity 0 → rx_o=0x1FF, no error. Then 0x1FF with the first stop bit 0 → rx_frame_error_o=1, FSM waits in WAIT_HIGH until the line returns high.
- fifo_els_p=4, ready held 0, send 0x11..0x15 → 4 entries held, overrun_o=1. Draining yields 0x11..0x14. overrun_clr_i clears overrun_o.
- Line held low for 20 bit times → exactly one rx_break_o pulse, no FIFO entry, busy_o until the line goes high. A 3-cycle low glitch at divisor 16 → no frame, returns to IDLE.
- Assert reset_i during data bit 4 with 2 entries queued → next cycle rx_v_o=0, busy_o=0. A following 0x5A frame is received correctly.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: 3-sample mid-bit majority vote, parity/framing/break
// detection, and a small receive FIFO with ready/valid output and sticky overrun.
module uart_rx_cfg #(
  parameter int unsigned max_data_bits_p = 9,
  parameter int unsigned clk_div_width_p = 16,
  parameter int unsigned fifo_els_p      = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       rx_i,
  input  logic [clk_div_width_p-1:0] cfg_clk_per_bit_i,
  input  logic [3:0]                 cfg_data_bits_i,
  input  logic                       cfg_parity_en_i,
  input  logic                       cfg_parity_odd_i,
  input  logic                       cfg_two_stop_i,
  output logic                       rx_v_o,
  output logic [max_data_bits_p-1:0] rx_o,
  output logic                       rx_parity_error_o,
  output logic                       rx_frame_error_o,
  input  logic                       rx_ready_and_i,
  output logic                       rx_break_o,
  output logic                       overrun_o,
  input  logic                       overrun_clr_i,
  output logic                       busy_o
);

  localparam int unsigned DataW  = max_data_bits_p;
  localparam int unsigned DivW   = clk_div_width_p;
  localparam int unsigned PtrW   = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
  localparam int unsigned CntW   = $clog2(fifo_els_p + 1);
  localparam int unsigned EntryW = DataW + 2;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StWaitHigh
  } state_e;

  state_e            state_q;
  logic              rx_s1_q, rx_s2_q, rx_prev_q;
  logic [DivW-1:0]   cnt_q;
  logic [DivW-1:0]   cfg_div_q;
  logic [3:0]        cfg_bits_q;
  logic              cfg_par_en_q, cfg_odd_q, cfg_two_q;
  logic [3:0]        bit_idx_q;
  logic [DataW-1:0]  data_q;
  logic              par_q;
  logic              ferr_q;
  logic              stop_idx_q;
  logic [1:0]        smp_q;
  logic              break_q;

  logic [EntryW-1:0] mem_q [fifo_els_p];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic              overrun_q;

  logic [DivW-1:0]   mid;
  logic              wrap, vote_pt, vote, is_last_stop, is_break;
  logic              push_en, do_push, pop, full, perr;
  logic [EntryW-1:0] push_entry, head;

  always_comb begin
    mid          = cfg_div_q >> 1;
    wrap         = (cnt_q == cfg_div_q - 1'b1);
    vote_pt      = (cnt_q == mid + 1'b1);
    vote         = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s2_q) | (smp_q[1] & rx_s2_q);
    is_last_stop = stop_idx_q | ~cfg_two_q;
    // Break is judged on the first stop bit only; the second one is never waited for.
    is_break     = (data_q == '0) && (!cfg_par_en_q || !par_q) && !vote && !stop_idx_q;
    push_en      = (state_q == StStop) && vote_pt && !is_break && is_last_stop;
    perr         = cfg_par_en_q & ((^data_q) ^ par_q ^ cfg_odd_q);
    push_entry   = {perr, ferr_q | ~vote, data_q};
    full         = (count_q == CntW'(fifo_els_p));
    pop          = rx_v_o & rx_ready_and_i;
    // A full FIFO still accepts a push when the head is leaving in the same cycle.
    do_push      = push_en & (~full | pop);
    head         = mem_q[rd_ptr_q];
  end

  assign rx_v_o            = (count_q != '0);
  assign rx_o              = rx_v_o ? head[DataW-1:0] : '0;
  assign rx_frame_error_o  = rx_v_o & head[DataW];
  assign rx_parity_error_o = rx_v_o & head[DataW+1];
  assign rx_break_o        = break_q;
  assign overrun_o         = overrun_q;
  assign busy_o            = (state_q != StIdle);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_prev_q    <= 1'b1;
      state_q      <= StIdle;
      cnt_q        <= '0;
      cfg_div_q    <= '0;
      cfg_bits_q   <= '0;
      cfg_par_en_q <= 1'b0;
      cfg_odd_q    <= 1'b0;
      cfg_two_q    <= 1'b0;
      bit_idx_q    <= '0;
      data_q       <= '0;
      par_q        <= 1'b0;
      ferr_q       <= 1'b0;
      stop_idx_q   <= 1'b0;
      smp_q        <= '0;
      break_q      <= 1'b0;
    end else begin
      rx_s1_q   <= rx_i;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      break_q   <= 1'b0;
      if (state_q inside {StStart, StData, StParity, StStop}) begin
        cnt_q <= wrap ? '0 : cnt_q + 1'b1;
        if (cnt_q == mid - 1'b1) smp_q[0] <= rx_s2_q;
        if (cnt_q == mid)        smp_q[1] <= rx_s2_q;
      end
      // Vote-point exits are written after wrap handling so they win at the minimum divisor.
      unique case (state_q)
        StIdle: begin
          if (rx_prev_q && !rx_s2_q) begin
            state_q      <= StStart;
            cnt_q        <= '0;
            cfg_div_q    <= cfg_clk_per_bit_i;
            cfg_bits_q   <= cfg_data_bits_i;
            cfg_par_en_q <= cfg_parity_en_i;
            cfg_odd_q    <= cfg_parity_odd_i;
            cfg_two_q    <= cfg_two_stop_i;
            bit_idx_q    <= '0;
            data_q       <= '0;
            par_q        <= 1'b0;
            ferr_q       <= 1'b0;
            stop_idx_q   <= 1'b0;
          end
        end
        StStart: begin
          if (wrap) state_q <= StData;
          if (vote_pt && vote) state_q <= StIdle;
        end
        StData: begin
          if (vote_pt && vote) data_q <= data_q | (DataW'(1) << bit_idx_q);
          if (wrap) begin
            if (bit_idx_q == cfg_bits_q - 4'd1) begin
              state_q <= cfg_par_en_q ? StParity : StStop;
            end else begin
              bit_idx_q <= bit_idx_q + 4'd1;
            end
          end
        end
        StParity: begin
          if (vote_pt) par_q <= vote;
          if (wrap) state_q <= StStop;
        end
        StStop: begin
          if (wrap) stop_idx_q <= 1'b1;
          if (vote_pt) begin
            if (is_break) begin
              break_q <= 1'b1;
              state_q <= StWaitHigh;
            end else if (is_last_stop) begin
              state_q <= vote ? StIdle : StWaitHigh;
            end else begin
              ferr_q <= ferr_q | ~vote;
            end
          end
        end
        StWaitHigh: begin
          if (rx_s2_q) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= (wr_ptr_q == PtrW'(fifo_els_p - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PtrW'(fifo_els_p - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      unique case ({do_push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (push_en && full && !pop) begin
        overrun_q <= 1'b1;
      end else if (overrun_clr_i) begin
        overrun_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: directed frames push expected entries, a negedge
// monitor pops and compares on every accepted FIFO head.
module tb_uart_rx_cfg;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        rx_i;
  logic [15:0] cfg_clk_per_bit_i;
  logic [3:0]  cfg_data_bits_i;
  logic        cfg_parity_en_i, cfg_parity_odd_i, cfg_two_stop_i;
  logic        rx_v_o;
  logic [8:0]  rx_o;
  logic        rx_parity_error_o, rx_frame_error_o;
  logic        rx_ready_and_i;
  logic        rx_break_o, overrun_o, overrun_clr_i, busy_o;

  always #5 clk_i = ~clk_i;

  uart_rx_cfg #(
    .max_data_bits_p(9),
    .clk_div_width_p(16),
    .fifo_els_p     (4)
  ) dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .rx_i             (rx_i),
    .cfg_clk_per_bit_i(cfg_clk_per_bit_i),
    .cfg_data_bits_i  (cfg_data_bits_i),
    .cfg_parity_en_i  (cfg_parity_en_i),
    .cfg_parity_odd_i (cfg_parity_odd_i),
    .cfg_two_stop_i   (cfg_two_stop_i),
    .rx_v_o           (rx_v_o),
    .rx_o             (rx_o),
    .rx_parity_error_o(rx_parity_error_o),
    .rx_frame_error_o (rx_frame_error_o),
    .rx_ready_and_i   (rx_ready_and_i),
    .rx_break_o       (rx_break_o),
    .overrun_o        (overrun_o),
    .overrun_clr_i    (overrun_clr_i),
    .busy_o           (busy_o)
  );

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_break  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: outputs and ready are stable at the falling edge.
  always @(negedge clk_i) begin
    exp_t e;
    if (!reset_i) begin
      if (rx_break_o) n_break++;
      if (rx_v_o && rx_ready_and_i) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pop: got 0x%0h, expected no entry", rx_o);
        end else begin
          e = exp_q.pop_front();
          check("rx_data", 32'(rx_o), 32'(e.data));
          check("parity_err", 32'(rx_parity_error_o), 32'(e.perr));
          check("frame_err", 32'(rx_frame_error_o), 32'(e.ferr));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic hold(input int n);
    repeat (n) step();
  endtask

  task automatic expect_frame(input logic [8:0] d, input logic pe, input logic fe);
    exp_t e;
    e.data = d;
    e.perr = pe;
    e.ferr = fe;
    exp_q.push_back(e);
  endtask

  task automatic set_cfg(input int div, input int bits, input bit pen, input bit odd,
                         input bit two);
    cfg_clk_per_bit_i = 16'(div);
    cfg_data_bits_i   = 4'(bits);
    cfg_parity_en_i   = pen;
    cfg_parity_odd_i  = odd;
    cfg_two_stop_i    = two;
  endtask

  // Line is left at the first stop value when nstop == 1.
  task automatic send_frame(input logic [8:0] d, input int nbits, input bit pen, input bit pbit,
                            input int nstop, input bit stop0, input int div);
    rx_i = 1'b0;
    hold(div);
    for (int i = 0; i < nbits; i++) begin
      rx_i = d[i];
      hold(div);
    end
    if (pen) begin
      rx_i = pbit;
      hold(div);
    end
    rx_i = stop0;
    hold(div);
    if (nstop == 2) begin
      rx_i = 1'b1;
      hold(div);
    end
  endtask

  task automatic wait_drain(input string name, input int max_cycles);
    for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) step();
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish before 2 ms");
    $fatal(1);
  end

  initial begin
    int lat;
    int nb0;
    logic [8:0] v5a;

    reset_i        = 1'b1;
    rx_i           = 1'b1;
    rx_ready_and_i = 1'b0;
    overrun_clr_i  = 1'b0;
    set_cfg(16, 8, 0, 0, 0);
    hold(3);
    check("reset_rx_v", 32'(rx_v_o), 32'd0);
    check("reset_rx_o", 32'(rx_o), 32'd0);
    check("reset_perr", 32'(rx_parity_error_o), 32'd0);
    check("reset_ferr", 32'(rx_frame_error_o), 32'd0);
    check("reset_break", 32'(rx_break_o), 32'd0);
    check("reset_overrun", 32'(overrun_o), 32'd0);
    check("reset_busy", 32'(busy_o), 32'd0);
    reset_i = 1'b0;
    hold(4);

    // 8N1 0xA5: stop vote at cycle 156 after the start drive, valid seen at the 158th negedge.
    rx_ready_and_i = 1'b1;
    expect_frame(9'h0A5, 1'b0, 1'b0);
    lat = 0;
    fork
      send_frame(9'h0A5, 8, 0, 0, 1, 1, 16);
      begin
        for (int i = 1; i <= 400; i++) begin
          @(negedge clk_i);
          if (rx_v_o) begin
            lat = i;
            break;
          end
        end
      end
    join
    check("valid_latency", 32'(lat), 32'd158);
    wait_drain("drain_8n1", 50);
    check("idle_after_8n1", 32'(busy_o), 32'd0);

    // 7E2 0x35: four ones, so parity bit 1 is wrong and 0 is right.
    set_cfg(16, 7, 1, 0, 1);
    expect_frame(9'h035, 1'b1, 1'b0);
    send_frame(9'h035, 7, 1, 1, 2, 1, 16);
    expect_frame(9'h035, 1'b0, 1'b0);
    send_frame(9'h035, 7, 1, 0, 2, 1, 16);
    wait_drain("drain_7e2", 50);

    // 9O1 0x1FF: nine ones, odd parity bit 0 is right; then a zero stop bit.
    set_cfg(8, 9, 1, 1, 0);
    expect_frame(9'h1FF, 1'b0, 1'b0);
    send_frame(9'h1FF, 9, 1, 0, 1, 1, 8);
    expect_frame(9'h1FF, 1'b0, 1'b1);
    send_frame(9'h1FF, 9, 1, 0, 1, 0, 8);
    hold(30);
    check("wait_high_busy", 32'(busy_o), 32'd1);
    rx_i = 1'b1;
    hold(6);
    check("wait_high_release", 32'(busy_o), 32'd0);
    wait_drain("drain_9o1", 50);

    // Overrun: five frames into a four-entry FIFO with no consumer.
    set_cfg(8, 8, 0, 0, 0);
    rx_ready_and_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) expect_frame(9'(8'h11 + i), 1'b0, 1'b0);
      send_frame(9'(8'h11 + i), 8, 0, 0, 1, 1, 8);
    end
    hold(10);
    check("overrun_set", 32'(overrun_o), 32'd1);
    check("full_head_valid", 32'(rx_v_o), 32'd1);
    check("full_head_data", 32'(rx_o), 32'h11);
    rx_ready_and_i = 1'b1;
    wait_drain("drain_overrun", 20);
    hold(2);
    check("overrun_sticky", 32'(overrun_o), 32'd1);
    overrun_clr_i = 1'b1;
    step();
    overrun_clr_i = 1'b0;
    check("overrun_clear", 32'(overrun_o), 32'd0);

    // Break: line low for 20 bit times at 8N1 / divisor 16.
    set_cfg(16, 8, 0, 0, 0);
    nb0  = n_break;
    rx_i = 1'b0;
    hold(320);
    check("break_busy", 32'(busy_o), 32'd1);
    rx_i = 1'b1;
    hold(6);
    check("break_release", 32'(busy_o), 32'd0);
    check("break_pulses", 32'(n_break - nb0), 32'd1);
    check("break_no_entry", 32'(rx_v_o), 32'd0);

    // Three-cycle glitch is rejected at the start-bit vote.
    nb0  = n_break;
    rx_i = 1'b0;
    hold(3);
    rx_i = 1'b1;
    hold(40);
    check("glitch_idle", 32'(busy_o), 32'd0);
    check("glitch_no_entry", 32'(rx_v_o), 32'd0);
    check("glitch_no_break", 32'(n_break - nb0), 32'd0);

    // Reset mid-frame with two entries queued discards everything.
    set_cfg(8, 8, 0, 0, 0);
    rx_ready_and_i = 1'b0;
    send_frame(9'h001, 8, 0, 0, 1, 1, 8);
    send_frame(9'h002, 8, 0, 0, 1, 1, 8);
    hold(2);
    check("pre_reset_valid", 32'(rx_v_o), 32'd1);
    v5a  = 9'h05A;
    rx_i = 1'b0;
    hold(8);
    for (int i = 0; i < 4; i++) begin
      rx_i = v5a[i];
      hold(8);
    end
    rx_i = v5a[4];
    hold(4);
    check("mid_frame_busy", 32'(busy_o), 32'd1);
    reset_i = 1'b1;
    rx_i    = 1'b1;
    step();
    check("reset_mid_valid", 32'(rx_v_o), 32'd0);
    check("reset_mid_busy", 32'(busy_o), 32'd0);
    reset_i = 1'b0;
    hold(20);
    rx_ready_and_i = 1'b1;
    expect_frame(9'h05A, 1'b0, 1'b0);
    send_frame(9'h05A, 8, 0, 0, 1, 1, 8);
    wait_drain("drain_after_reset", 50);
    hold(10);
    check("final_empty", 32'(rx_v_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
